// File: rtl/cambricon_pkg.sv
// rtl/cambricon_pkg.sv - shared constants and element record for the delta encoding path
package cambricon_pkg;

    localparam int INPUT_SIZE = 128;
    localparam int DATA_W     = 32;
    localparam int M          = 4;
    localparam int IDX_W      = $clog2(INPUT_SIZE);
    localparam int CNT_W      = IDX_W + 1;

    localparam logic signed [DATA_W-1:0] INT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] INT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    // Per-element record handed to the PE array delta path and SFU wrappers.
    typedef struct packed {
        logic [M-1:0]      q;
        logic              outlier;
        logic [DATA_W-1:0] delta;
        logic              sign;
        logic              sat;
        logic [IDX_W-1:0]  idx;
        logic              last;
    } delta_elem_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } enc_state_t;

endpackage

// File: rtl/delta_classifier.sv
// rtl/delta_classifier.sv - combinational subtract, saturate, classify and quantize of one element
module delta_classifier
    import cambricon_pkg::*;
(
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] prev,
    output logic [M-1:0]      q,
    output logic              outlier,
    output logic [DATA_W-1:0] delta,
    output logic              sign,
    output logic              sat
);

    logic [DATA_W:0] d;
    logic            inlier;

    assign d = {x[DATA_W-1], x} - {prev[DATA_W-1], prev};

    // The one-bit-wider difference overflows DATA_W exactly when its top two bits disagree.
    assign sat   = d[DATA_W] ^ d[DATA_W-1];
    assign sign  = d[DATA_W];
    assign delta = sat ? (d[DATA_W] ? INT_MIN : INT_MAX) : d[DATA_W-1:0];

    // Fits in M signed bits iff every bit from M-1 upward is a copy of the sign.
    assign inlier  = (&d[DATA_W:M-1]) | ~(|d[DATA_W:M-1]);
    assign outlier = ~inlier;
    assign q       = inlier ? d[M-1:0] : '0;

endmodule

// File: rtl/delta_encoder.sv
// rtl/delta_encoder.sv - streaming temporal delta encoder with per-element history and outlier bitmap
module delta_encoder
    import cambricon_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [M-1:0]      out_q,
    output logic              out_outlier,
    output logic [DATA_W-1:0] out_delta,
    output logic              out_sign,
    output logic              out_sat,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last,
    output logic [CNT_W-1:0]  outlier_cnt
);

    enc_state_t        state;
    enc_state_t        state_nxt;
    logic [IDX_W-1:0]  idx;
    logic [CNT_W-1:0]  run_cnt;
    logic [DATA_W-1:0] hist [INPUT_SIZE];
    logic [INPUT_SIZE-1:0] hist_vld;
    delta_elem_t       out_reg;
    delta_elem_t       elem;

    logic              flush_pending;
    logic              accept;
    logic              is_last;
    logic [DATA_W-1:0] prev;
    logic [M-1:0]      cls_q;
    logic              cls_outlier;
    logic [DATA_W-1:0] cls_delta;
    logic              cls_sign;
    logic              cls_sat;

    // A flush is only honoured between vectors; mid-vector it is ignored.
    assign flush_pending = (state == ST_IDLE) & flush;
    assign in_ready      = ~rst & ~flush_pending & (~out_valid | out_ready);
    assign accept        = in_valid & in_ready;
    assign is_last       = (idx == IDX_W'(INPUT_SIZE - 1));
    assign prev          = hist_vld[idx] ? hist[idx] : '0;

    delta_classifier u_classifier (
        .x       (in_data),
        .prev    (prev),
        .q       (cls_q),
        .outlier (cls_outlier),
        .delta   (cls_delta),
        .sign    (cls_sign),
        .sat     (cls_sat)
    );

    always_comb begin
        elem.q       = cls_q;
        elem.outlier = cls_outlier;
        elem.delta   = cls_delta;
        elem.sign    = cls_sign;
        elem.sat     = cls_sat;
        elem.idx     = idx;
        elem.last    = is_last;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (accept) state_nxt = is_last ? ST_IDLE : ST_STREAM;
            ST_STREAM: if (accept && is_last) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // History payload needs no reset: it is never read while its valid bit is clear.
    always_ff @(posedge clk) begin
        if (accept) begin
            hist[idx] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            idx         <= '0;
            hist_vld    <= '0;
            run_cnt     <= '0;
            outlier_cnt <= '0;
            out_valid   <= 1'b0;
            out_reg     <= '0;
        end else begin
            state <= state_nxt;

            if (flush_pending) begin
                hist_vld <= '0;
            end else if (accept) begin
                hist_vld[idx] <= 1'b1;
            end

            if (accept) begin
                out_reg   <= elem;
                out_valid <= 1'b1;
                if (is_last) begin
                    idx         <= '0;
                    outlier_cnt <= run_cnt + CNT_W'(cls_outlier);
                    run_cnt     <= '0;
                end else begin
                    idx     <= idx + 1'b1;
                    run_cnt <= run_cnt + CNT_W'(cls_outlier);
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign out_q       = out_reg.q;
    assign out_outlier = out_reg.outlier;
    assign out_delta   = out_reg.delta;
    assign out_sign    = out_reg.sign;
    assign out_sat     = out_reg.sat;
    assign out_idx     = out_reg.idx;
    assign out_last    = out_reg.last;

endmodule
